// File: rtl/lcd_text_arbiter.sv
// lcd_text_arbiter
// Character buffer (2**ADDR_W x 8) read by the HD44780 4-bit driver. Two
// writers share the buffer through a round-robin arbiter. A small scheduler
// issues one lcd_trg pulse whenever the buffer is dirty, the driver is idle
// and the post-print holdoff has elapsed.
// Build option: define LCD_ARB_AUTOREFRESH_EN for a periodic forced re-print.
//
// state   | meaning
// CLEAR   | fill every entry with FILL_CHAR after reset, writers held off
// IDLE    | wait for dirty, driver idle and holdoff expired
// TRIG    | one-cycle print trigger to the driver
// WAIT_HI | wait for the driver to raise busy (bounded by BUSY_TIMEOUT)
// WAIT_LO | wait for the print to finish, then start the holdoff
module lcd_text_arbiter #(
  parameter int         ADDR_W         = 6,
  parameter int         HOLDOFF_CYCLES = 250,
  parameter int         BUSY_TIMEOUT   = 4,
  parameter int         REFRESH_CYCLES = 250000,
  parameter logic [7:0] FILL_CHAR      = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [7:0]        req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [7:0]        req1_data,
  output logic              req1_ready,
  input  logic              lcd_busy,
  output logic              lcd_trg,
  input  logic [ADDR_W-1:0] lcd_addr,
  output logic [7:0]        lcd_data,
  output logic              dirty,
  output logic              clearing
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int HO_W  = $clog2(HOLDOFF_CYCLES + 1);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_IDLE    = 3'd1,
    S_TRIG    = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_last;
  logic              rr_ptr;       // 0: req0 wins a tie, 1: req1 wins a tie
  logic [HO_W-1:0]   holdoff_cnt;
  logic              holdoff_done;
  logic [TO_W-1:0]   tmo_cnt;
  logic              busy_timeout;
  logic              wr_commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              dirty_set;
  logic              refresh_wrap;

  assign clr_last     = (clr_idx == {ADDR_W{1'b1}});
  assign holdoff_done = (holdoff_cnt == '0);
  assign busy_timeout = (state_q == S_WAIT_HI) && !lcd_busy && (tmo_cnt == TO_W'(1));
  assign wr_commit    = req0_ready | req1_ready;
  assign wr_addr      = req0_ready ? req0_addr : req1_addr;
  assign wr_data      = req0_ready ? req0_data : req1_data;
  assign dirty_set    = wr_commit || busy_timeout || refresh_wrap ||
                        ((state_q == S_CLEAR) && clr_last);

`ifdef LCD_ARB_AUTOREFRESH_EN
  localparam int RF_W = $clog2(REFRESH_CYCLES);
  logic [RF_W-1:0] refresh_cnt;

  assign refresh_wrap = (refresh_cnt == '0);

  // Free-running refresh down-counter, restarted by every print trigger
  always_ff @(posedge clk) begin
    if (rst || state_q == S_TRIG) begin
      refresh_cnt <= RF_W'(REFRESH_CYCLES - 1);
    end else if (refresh_wrap) begin
      refresh_cnt <= RF_W'(REFRESH_CYCLES - 1);
    end else begin
      refresh_cnt <= refresh_cnt - 1'b1;
    end
  end
`else
  // Autorefresh absent: the comparison is constant false
  assign refresh_wrap = (REFRESH_CYCLES < 0);
`endif

  // Scheduler state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Scheduler next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR:   if (clr_last) state_d = S_IDLE;
      S_IDLE:    if (dirty && !lcd_busy && holdoff_done) state_d = S_TRIG;
      S_TRIG:    state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (lcd_busy) begin
          state_d = S_WAIT_LO;
        end else if (busy_timeout) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_LO: if (!lcd_busy) state_d = S_IDLE;
      default:   state_d = S_CLEAR;
    endcase
  end

  // Moore outputs and combinational round-robin grants
  always_comb begin
    lcd_trg    = (state_q == S_TRIG);
    clearing   = (state_q == S_CLEAR);
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q != S_CLEAR) begin
      req0_ready = req0_valid && (!req1_valid || !rr_ptr);
      req1_ready = req1_valid && (!req0_valid ||  rr_ptr);
    end
  end

  // Clear index, arbitration pointer, dirty flag, holdoff and busy timers
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx     <= '0;
      rr_ptr      <= 1'b0;
      dirty       <= 1'b0;
      holdoff_cnt <= '0;
      tmo_cnt     <= '0;
    end else begin
      if (state_q == S_CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
      end

      // after a grant the other requester wins the next tie
      if (wr_commit) begin
        rr_ptr <= req0_ready;
      end

      // a write in the trigger cycle keeps the buffer dirty
      if (dirty_set) begin
        dirty <= 1'b1;
      end else if (state_q == S_TRIG) begin
        dirty <= 1'b0;
      end

      if (state_q == S_WAIT_LO && !lcd_busy) begin
        holdoff_cnt <= HO_W'(HOLDOFF_CYCLES);
      end else if (state_q == S_IDLE && !holdoff_done) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end

      if (state_q == S_TRIG) begin
        tmo_cnt <= TO_W'(BUSY_TIMEOUT);
      end else if (state_q == S_WAIT_HI && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
    end
  end

  // Buffer write port: fill pattern during CLEAR, arbitrated writes otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        mem[clr_idx] <= FILL_CHAR;
      end else if (wr_commit) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  // Registered read port; a same-cycle write to the same entry returns old data
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_data <= 8'h00;
    end else begin
      lcd_data <= mem[lcd_addr];
    end
  end

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Testbench for lcd_text_arbiter: scoreboard of expected outputs keyed by the
// cycle in which they must appear, checked on the falling clock edge.
module tb_lcd_text_arbiter;

  localparam int ADDR_W  = 6;
  localparam int HOLDOFF = 250;

  localparam int K_DATA  = 0;
  localparam int K_RDY   = 1;
  localparam int K_TRG   = 2;
  localparam int K_DIRTY = 3;
  localparam int K_CLR   = 4;

  typedef struct {
    int         due;
    int         kind;
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [7:0]        req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              lcd_busy;
  logic              lcd_trg;
  logic [ADDR_W-1:0] lcd_addr;
  logic [7:0]        lcd_data;
  logic              dirty;
  logic              clearing;

  logic [7:0] model [64];
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  lcd_text_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .lcd_busy   (lcd_busy),
    .lcd_trg    (lcd_trg),
    .lcd_addr   (lcd_addr),
    .lcd_data   (lcd_data),
    .dirty      (dirty),
    .clearing   (clearing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int dly, input int kind, input string tag, input logic [7:0] v);
    sb_t e;
    e.due  = cyc + dly;
    e.kind = kind;
    e.tag  = tag;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // pop and compare every scoreboard entry due in this cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      sb_t         e;
      logic [31:0] got;
      e   = sb[i];
      got = '0;
      if (e.due <= cyc) begin
        case (e.kind)
          K_DATA:  got = {24'h0, lcd_data};
          K_RDY:   got = {30'h0, req1_ready, req0_ready};
          K_TRG:   got = {31'h0, lcd_trg};
          K_DIRTY: got = {31'h0, dirty};
          default: got = {31'h0, clearing};
        endcase
        check_eq(e.tag, got, {24'h0, e.exp});
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_fill();
    for (int i = 0; i < 64; i++) model[i] = 8'h20;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input string tag);
    lcd_addr = a;
    expect_at(1, K_DATA, tag, model[a]);
  endtask

  task automatic wait_trg(input int max_cyc, input string tag, output int at);
    int n;
    logic found;
    n     = 0;
    found = 1'b0;
    at    = -1;
    while (!found && n <= max_cyc) begin
      if (lcd_trg === 1'b1) begin
        found = 1'b1;
        at    = cyc;
      end else begin
        step(1);
        n++;
      end
    end
    check_eq(tag, found, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
    $fatal(1);
  end

  initial begin
    int t, f, n;
    rst        = 1'b1;
    req0_valid = 1'b1; req0_addr = 6'd5; req0_data = 8'h41;
    req1_valid = 1'b1; req1_addr = 6'd6; req1_data = 8'h42;
    lcd_busy   = 1'b0;
    lcd_addr   = '0;
    model_fill();

    // reset values
    step(1);
    expect_at(0, K_CLR,   "rst_clearing", 1);
    expect_at(0, K_DIRTY, "rst_dirty", 0);
    expect_at(0, K_TRG,   "rst_trg", 0);
    expect_at(0, K_RDY,   "rst_ready", 0);
    expect_at(0, K_DATA,  "rst_data", 0);
    step(2);
    rst = 1'b0;

    // 64-cycle clear; requests are held off despite valid
    for (int i = 0; i < 64; i++) begin
      expect_at(0, K_CLR, "clear_active", 1);
      expect_at(0, K_RDY, "clear_no_ready", 0);
      step(1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    expect_at(0, K_CLR,   "clear_done", 0);
    expect_at(0, K_DIRTY, "clear_dirty", 1);
    expect_at(0, K_TRG,   "idle_no_trg", 0);
    expect_at(1, K_TRG,   "first_trg", 1);
    expect_at(2, K_TRG,   "trg_one_cycle", 0);
    expect_at(2, K_DIRTY, "trg_clears_dirty", 0);
    step(2);
    lcd_busy = 1'b1;
    step(1);
    rd(6'd0,  "rd_clear0");  step(1);
    rd(6'd37, "rd_clear37"); step(1);
    rd(6'd63, "rd_clear63"); step(1);
    lcd_busy = 1'b0;
    f = cyc;
    step(1);

    // both requesters every cycle: grants alternate starting with req0
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      expect_at(0, K_RDY, "rr_grant", (k % 2 == 0) ? 8'd1 : 8'd2);
      if (k % 2 == 0) model[5] = 8'h41;
      else            model[6] = 8'h42;
      step(1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    expect_at(0, K_DIRTY, "write_sets_dirty", 1);
    rd(6'd5, "rd_alt5"); step(1);
    rd(6'd6, "rd_alt6"); step(1);
    wait_trg(400, "trg_after_writes", t);
    check_eq("holdoff_respected", (t - f >= HOLDOFF), 1);
    expect_at(1, K_DIRTY, "trg2_clears", 0);

    // write during WAIT_LO -> exactly one follow-up trigger after holdoff
    step(1);
    lcd_busy = 1'b1;
    step(1);
    req0_valid = 1'b1; req0_addr = 6'd10; req0_data = 8'h55;
    expect_at(0, K_RDY,   "wlo_grant", 1);
    expect_at(1, K_DIRTY, "wlo_write_dirty", 1);
    model[10] = 8'h55;
    step(1);
    req0_valid = 1'b0;
    step(3);
    lcd_busy = 1'b0;
    f = cyc;
    wait_trg(400, "trg_after_wlo", t);
    check_eq("wlo_holdoff_min", (t - f >= HOLDOFF), 1);
    check_eq("wlo_holdoff_max", (t - f <= HOLDOFF + 2), 1);
    step(1);
    lcd_busy = 1'b1;
    step(3);
    lcd_busy = 1'b0;
    step(1);
    expect_at(0, K_DIRTY, "idle_clean", 0);
    n = 0;
    repeat (600) begin
      if (lcd_trg === 1'b1) n++;
      step(1);
    end
    check_eq("single_followup", n, 0);

    // busy never rises after trg: timeout re-dirties and re-triggers
    req1_valid = 1'b1; req1_addr = 6'd7; req1_data = 8'h44;
    expect_at(0, K_RDY, "single_req1", 2);
    model[7] = 8'h44;
    step(1);
    req1_valid = 1'b0;
    wait_trg(10, "trg_for_timeout", t);
    expect_at(1, K_DIRTY, "tmo_wait_clean", 0);
    expect_at(4, K_DIRTY, "tmo_still_waiting", 0);
    expect_at(5, K_DIRTY, "tmo_redirty", 1);
    expect_at(5, K_TRG,   "tmo_idle_no_trg", 0);
    expect_at(6, K_TRG,   "tmo_retrg", 1);
    step(7);
    lcd_busy = 1'b1;
    step(1);

    // read latency and same-cycle read/write collision
    rd(6'd5, "rd5_before"); step(1);
    req0_valid = 1'b1; req0_addr = 6'd5; req0_data = 8'h43;
    rd(6'd5, "rd5_collide");
    expect_at(0, K_RDY, "collide_grant", 1);
    model[5] = 8'h43;
    step(1);
    req0_valid = 1'b0;
    rd(6'd5,  "rd5_after"); step(1);
    rd(6'd7,  "rd7");       step(1);
    rd(6'd10, "rd10");      step(1);
    rd(6'd6,  "rd6");       step(1);

    // reset in WAIT_LO: outputs return to reset values, buffer re-cleared
    expect_at(0, K_DIRTY, "pre_rst_dirty", 1);
    rst = 1'b1;
    expect_at(1, K_TRG,   "mid_rst_trg", 0);
    expect_at(1, K_DIRTY, "mid_rst_dirty", 0);
    expect_at(1, K_CLR,   "mid_rst_clearing", 1);
    expect_at(1, K_DATA,  "mid_rst_data", 0);
    step(1);
    rst = 1'b0;
    model_fill();
    expect_at(30, K_CLR, "reclear_mid", 1);
    step(64);
    expect_at(0, K_CLR,   "reclear_done", 0);
    expect_at(0, K_DIRTY, "reclear_dirty", 1);
    n = 0;
    repeat (10) begin
      if (lcd_trg === 1'b1) n++;
      step(1);
    end
    check_eq("busy_inhibits_trg", n, 0);
    lcd_busy = 1'b0;
    wait_trg(3, "trg_after_busy_low", t);
    rd(6'd5,  "rd5_recleared");  step(1);
    rd(6'd63, "rd63_recleared"); step(1);
    step(2);
    check_eq("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_text_arbiter.md
Name: lcd_text_arbiter

Overview:
- Owns the 64x8 character buffer read by the HD44780 4-bit driver over its idataaddr/idata port.
- Shares write access to the buffer between two requesters using round-robin arbitration.
- Schedules the driver's print trigger: one trg pulse whenever the buffer is dirty, the driver is idle and a holdoff interval has elapsed.
- Sits between application logic and hd44780 in the 250 kHz LCD clock domain.

Parameters:
- ADDR_W, 6, buffer address width; depth = 2**ADDR_W = 64 (4 lines x 16 chars).
- HOLDOFF_CYCLES, 250, minimum cycles from busy falling to the next trg (1 ms at 250 kHz).
- BUSY_TIMEOUT, 4, cycles allowed after trg for lcd_busy to rise.
- REFRESH_CYCLES, 250000, autorefresh period (optional feature only).
- FILL_CHAR, 8'h20, value written to every entry during the clear sequence.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- req0_valid, input, 1, requester 0 write request.
- req0_addr, input, ADDR_W, requester 0 buffer address.
- req0_data, input, 8, requester 0 character.
- req0_ready, output, 1, requester 0 grant; a write commits on valid&ready.
- req1_valid, input, 1, requester 1 write request.
- req1_addr, input, ADDR_W, requester 1 buffer address.
- req1_data, input, 8, requester 1 character.
- req1_ready, output, 1, requester 1 grant.
- lcd_busy, input, 1, driver busy.
- lcd_trg, output, 1, one-cycle print trigger to the driver.
- lcd_addr, input, ADDR_W, driver read address.
- lcd_data, output, 8, registered read data.
- dirty, output, 1, buffer modified since the last trg.
- clearing, output, 1, clear sequence in progress.

Behaviour:
- Reset values: lcd_trg=0, lcd_data=0, dirty=0, clearing=1, req*_ready=0, round-robin pointer favours req0, holdoff counter=0 (expired), state=CLEAR, clear index=0.
- CLEAR state:
  - Writes FILL_CHAR to entry[idx] each cycle; idx counts 0..63.
  - After writing entry 63: clearing=0, dirty=1, go to IDLE. Total 64 cycles.
  - Both ready outputs stay 0 throughout.
- Arbitration (all states except CLEAR):
  - ready is combinational from valid and the pointer. At most one ready is high per cycle.
  - Single valid: that requester is granted.
  - Both valid: the pointer's requester is granted. After any committed grant, the pointer moves to the other requester.
  - A committed write updates the RAM at the clock edge and sets dirty=1 the same edge, even if the data is unchanged.
- Read port:
  - lcd_data <= mem[lcd_addr] every cycle; latency 1.
  - A write and a read to the same address in the same cycle returns the old data.
- Scheduler FSM states:
  - IDLE: when dirty & !lcd_busy & holdoff expired, go to TRIG.
  - TRIG: lcd_trg=1 for exactly one cycle; dirty cleared at this edge unless a write commits in the same cycle (write wins, dirty stays 1); go to WAIT_HI.
  - WAIT_HI: when lcd_busy=1, go to WAIT_LO. If BUSY_TIMEOUT cycles pass without busy, set dirty=1 and go to IDLE.
  - WAIT_LO: when lcd_busy=0, load the holdoff counter with HOLDOFF_CYCLES and go to IDLE. The counter decrements to 0 in IDLE.
- Writes are accepted in every scheduler state. A write during WAIT_HI/WAIT_LO re-sets dirty, which guarantees exactly one follow-up refresh.
- A lcd_busy high while in IDLE (driver reset sequence) inhibits trg. No trg is issued before lcd_busy is first seen low.
- rst asserted mid-operation: immediate return to reset values, buffer re-cleared, any trg in flight is dropped.

Optional Feature:
LCD_ARB_AUTOREFRESH_EN
- Defined: a free-running counter of REFRESH_CYCLES sets dirty=1 on wrap, giving periodic re-prints that recover from LCD glitches. The counter resets on rst and on every trg.
- Undefined: trg is issued only on buffer writes and after the clear sequence; the counter logic is absent.

Test Plan:
- Reset, lcd_busy=0 -> clearing high for 64 cycles, then dirty=1, one lcd_trg pulse; read of any address returns 8'h20.
- req0 and req1 valid every cycle with addr 5 and 6, data 8'h41 and 8'h42 -> grants alternate req0, req1, req0, ...; mem[5]=8'h41, mem[6]=8'h42; a single write never produces two readys.
- Write during WAIT_LO, busy falls -> exactly one further trg, issued HOLDOFF_CYCLES=250 cycles after busy falls, not earlier.
- trg issued, lcd_busy held 0 -> after 4 cycles the FSM returns to IDLE with dirty=1; trg re-issued once holdoff expires.
- lcd_addr=5 after the write above -> lcd_data=8'h41 one cycle later; a same-cycle write of 8'h43 to addr 5 still reads 8'h41, then 8'h43 the next cycle.
- rst asserted while in WAIT_LO -> lcd_trg=0, dirty=0, clearing=1 the next cycle; the buffer reads 8'h20 after 64 cycles.
